alu_share_arb: RTL and testbench

//  Shares the single EX-stage ALU between requester A (CPU pipeline EX) and

---
 rtl/alu_share_arb_pkg.sv | 31 +++
 rtl/alu_share_arb_sat_cnt.sv | 27 ++
 rtl/alu_share_arb.sv | 135 +++++++++++++
 tb/tb_alu_share_arb.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the EX-stage ALU arbiter: ALU function codes, arbiter
// state encodings and the operand bundle steered onto the ALU.
package alu_share_arb_pkg;

  localparam logic [2:0] FUNC_ADD = 3'd0;
  localparam logic [2:0] FUNC_SUB = 3'd1;
  localparam logic [2:0] FUNC_AND = 3'd2;
  localparam logic [2:0] FUNC_NOR = 3'd3;
  localparam logic [2:0] FUNC_SLL = 3'd4;
  localparam logic [2:0] FUNC_SRL = 3'd5;
  localparam logic [2:0] FUNC_SRA = 3'd6;
  localparam logic [2:0] FUNC_LHB = 3'd7;

  localparam logic [0:0] ARB_A   = 1'b0;
  localparam logic [0:0] ARB_BLK = 1'b1;

  localparam int unsigned DEF_MAX_WAIT  = 8;
  localparam int unsigned DEF_MAX_BURST = 4;

  typedef struct packed {
    logic [32:0] src0;
    logic [32:0] src1;
    logic [2:0]  func;
    logic [4:0]  shamt;
  } alu_op_t;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/alu_share_arb_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_sat_cnt #(
  parameter int unsigned MAX = 8,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic         w_at_max;

  assign w_at_max = (r_cnt == W'(MAX));
  assign o_cnt    = r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one EX-stage ALU between the CPU pipeline (A, priority) and an
// accelerator (B) with a starvation bound and bounded locked bursts for B.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT  = DEF_MAX_WAIT,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic [32:0] a_src0,
  input  logic [32:0] a_src1,
  input  logic [2:0]  a_func,
  input  logic [4:0]  a_shamt,
  output logic        a_gnt,
  input  logic        b_req,
  input  logic        b_lock,
  input  logic [32:0] b_src0,
  input  logic [32:0] b_src1,
  input  logic [2:0]  b_func,
  input  logic [4:0]  b_shamt,
  output logic        b_gnt,
  output logic [32:0] alu_src0,
  output logic [32:0] alu_src1,
  output logic [2:0]  alu_func,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_dst_EX_DM,
  input  logic        alu_ov,
  input  logic        alu_zr,
  input  logic        alu_neg,
  output logic        a_rsp_vld,
  output logic        b_rsp_vld,
  output logic [31:0] rsp_dst,
  output logic        rsp_ov,
  output logic        rsp_zr,
  output logic        rsp_neg
);

  localparam int unsigned WW = cnt_width(MAX_WAIT);
  localparam int unsigned BW = cnt_width(MAX_BURST);

  logic [0:0]    r_state;
  logic [0:0]    w_state_next;
  logic          r_a_rsp_vld;
  logic          r_b_rsp_vld;
  logic          r_rsp_ov;
  logic          r_rsp_zr;
  logic          r_rsp_neg;
  logic          w_a_gnt;
  logic          w_b_gnt;
  logic [WW-1:0] w_wait_cnt;
  logic [BW-1:0] w_burst_cnt;
  logic          w_wait_sat;
  logic          w_burst_sat;
  alu_op_t       w_a_op;
  alu_op_t       w_b_op;
  alu_op_t       w_alu_op;

  assign w_wait_sat  = (w_wait_cnt == WW'(MAX_WAIT));
  assign w_burst_sat = (w_burst_cnt == BW'(MAX_BURST));

  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (!rst) begin
      if (r_state == ARB_A) begin
        w_b_gnt = b_req && (!a_req || w_wait_sat);
      end else begin
        w_b_gnt = b_req && !w_burst_sat;
      end
      w_a_gnt = a_req && !w_b_gnt;
    end
  end

  // Only a locked B grant keeps (or puts) us in the burst state; anything else,
  // including an unused slot, hands priority back to A.
  assign w_state_next = (w_b_gnt && b_lock) ? ARB_BLK : ARB_A;

  arb_sat_cnt #(.MAX(MAX_WAIT), .W(WW)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_b_gnt || !b_req),
    .i_inc (b_req && !w_b_gnt),
    .o_cnt (w_wait_cnt)
  );

  arb_sat_cnt #(.MAX(MAX_BURST), .W(BW)) u_burst_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_state_next == ARB_A),
    .i_inc (w_b_gnt && (w_state_next == ARB_BLK)),
    .o_cnt (w_burst_cnt)
  );

  // A owns the ALU inputs unless B is actually granted.
  assign w_a_op   = '{src0: a_src0, src1: a_src1, func: a_func, shamt: a_shamt};
  assign w_b_op   = '{src0: b_src0, src1: b_src1, func: b_func, shamt: b_shamt};
  assign w_alu_op = w_b_gnt ? w_b_op : w_a_op;

  assign alu_src0  = w_alu_op.src0;
  assign alu_src1  = w_alu_op.src1;
  assign alu_func  = w_alu_op.func;
  assign alu_shamt = w_alu_op.shamt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_A;
      r_a_rsp_vld <= 1'b0;
      r_b_rsp_vld <= 1'b0;
      r_rsp_ov    <= 1'b0;
      r_rsp_zr    <= 1'b0;
      r_rsp_neg   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_a_rsp_vld <= w_a_gnt;
      r_b_rsp_vld <= w_b_gnt;
      if (w_a_gnt || w_b_gnt) begin
        r_rsp_ov  <= alu_ov;
        r_rsp_zr  <= alu_zr;
        r_rsp_neg <= alu_neg;
      end
    end
  end

  assign a_gnt     = w_a_gnt;
  assign b_gnt     = w_b_gnt;
  assign a_rsp_vld = r_a_rsp_vld;
  assign b_rsp_vld = r_b_rsp_vld;
  assign rsp_dst   = alu_dst_EX_DM;
  assign rsp_ov    = r_rsp_ov;
  assign rsp_zr    = r_rsp_zr;
  assign rsp_neg   = r_rsp_neg;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a small saturating ALU model standing
// in for the parent's EX-stage ALU (combinational flags, flopped result).
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, b_req, b_lock;
  logic [32:0] a_src0, a_src1, b_src0, b_src1;
  logic [2:0]  a_func, b_func;
  logic [4:0]  a_shamt, b_shamt;
  logic        a_gnt, b_gnt;
  logic [32:0] alu_src0, alu_src1;
  logic [2:0]  alu_func;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_dst_EX_DM;
  logic        alu_ov, alu_zr, alu_neg;
  logic        a_rsp_vld, b_rsp_vld;
  logic [31:0] rsp_dst;
  logic        rsp_ov, rsp_zr, rsp_neg;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_share_arb dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_src0(a_src0), .a_src1(a_src1), .a_func(a_func), .a_shamt(a_shamt),
    .a_gnt(a_gnt),
    .b_req(b_req), .b_lock(b_lock), .b_src0(b_src0), .b_src1(b_src1), .b_func(b_func),
    .b_shamt(b_shamt), .b_gnt(b_gnt),
    .alu_src0(alu_src0), .alu_src1(alu_src1), .alu_func(alu_func), .alu_shamt(alu_shamt),
    .alu_dst_EX_DM(alu_dst_EX_DM), .alu_ov(alu_ov), .alu_zr(alu_zr), .alu_neg(alu_neg),
    .a_rsp_vld(a_rsp_vld), .b_rsp_vld(b_rsp_vld), .rsp_dst(rsp_dst),
    .rsp_ov(rsp_ov), .rsp_zr(rsp_zr), .rsp_neg(rsp_neg)
  );

  // ALU model: saturating ADD/SUB on the low 32 bits of each operand.
  logic [31:0] m_s0, m_s1, m_raw, m_res;
  logic        m_ov;
  always_comb begin
    m_s0  = alu_src0[31:0];
    m_s1  = alu_src1[31:0];
    m_raw = 32'h0;
    m_ov  = 1'b0;
    case (alu_func)
      FUNC_ADD: begin
        m_raw = m_s0 + m_s1;
        m_ov  = (m_s0[31] == m_s1[31]) && (m_raw[31] != m_s0[31]);
      end
      FUNC_SUB: begin
        m_raw = m_s0 - m_s1;
        m_ov  = (m_s0[31] != m_s1[31]) && (m_raw[31] != m_s0[31]);
      end
      FUNC_AND: m_raw = m_s0 & m_s1;
      FUNC_NOR: m_raw = ~(m_s0 | m_s1);
      FUNC_SLL: m_raw = m_s0 << alu_shamt;
      FUNC_SRL: m_raw = m_s0 >> alu_shamt;
      FUNC_SRA: m_raw = $unsigned($signed(m_s0) >>> alu_shamt);
      default:  m_raw = {m_s1[15:0], m_s0[15:0]};
    endcase
    m_res   = m_ov ? (m_s0[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : m_raw;
    alu_ov  = m_ov;
    alu_zr  = (m_res == 32'h0);
    alu_neg = m_res[31];
  end

  always @(posedge clk) alu_dst_EX_DM <= m_res;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic req, input logic [32:0] s0, input logic [32:0] s1,
                       input logic [2:0] f);
    a_req = req; a_src0 = s0; a_src1 = s1; a_func = f; a_shamt = 5'd0;
  endtask

  task automatic set_b(input logic req, input logic lock, input logic [32:0] s0,
                       input logic [32:0] s1, input logic [2:0] f);
    b_req = req; b_lock = lock; b_src0 = s0; b_src1 = s1; b_func = f; b_shamt = 5'd0;
  endtask

  logic exp_burst [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic prev_a, prev_b;

  initial begin
    rst = 1'b1;
    set_a(1'b0, 33'd0, 33'd0, FUNC_ADD);
    set_b(1'b0, 1'b0, 33'd0, 33'd0, FUNC_ADD);
    repeat (2) tick();

    // Reset: grants suppressed even with both requesting, registers cleared.
    set_a(1'b1, 33'd3, 33'd4, FUNC_ADD);
    set_b(1'b1, 1'b1, 33'd1, 33'd1, FUNC_ADD);
    #1;
    chk1("rst_a_gnt", a_gnt, 1'b0);
    chk1("rst_b_gnt", b_gnt, 1'b0);
    tick();
    chk1("rst_a_vld", a_rsp_vld, 1'b0);
    chk1("rst_b_vld", b_rsp_vld, 1'b0);
    chk1("rst_ov", rsp_ov, 1'b0);
    chk1("rst_zr", rsp_zr, 1'b0);
    chk1("rst_neg", rsp_neg, 1'b0);

    // A alone: ADD 3+4.
    rst = 1'b0;
    set_b(1'b0, 1'b0, 33'd0, 33'd0, FUNC_ADD);
    #1;
    chk1("a_only_gnt", a_gnt, 1'b1);
    chk1("a_only_bgnt", b_gnt, 1'b0);
    chk32("a_only_src0", alu_src0[31:0], 32'd3);
    tick();
    chk1("a_only_vld", a_rsp_vld, 1'b1);
    chk1("a_only_bvld", b_rsp_vld, 1'b0);
    chk32("a_only_dst", rsp_dst, 32'd7);
    chk1("a_only_zr", rsp_zr, 1'b0);
    $display("[TB] A ADD 3+4 -> dst=%0d", rsp_dst);

    // Starvation bound: A continuous, B waits 8 cycles then wins once.
    set_a(1'b1, 33'd1, 33'd1, FUNC_ADD);
    set_b(1'b1, 1'b0, 33'd10, 33'd3, FUNC_SUB);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk1("starve_a_gnt", a_gnt, 1'b1);
      chk1("starve_b_gnt", b_gnt, 1'b0);
      tick();
    end
    #1;
    chk1("forced_b_gnt", b_gnt, 1'b1);
    chk1("forced_a_stall", a_gnt, 1'b0);
    chk32("forced_func", 32'(alu_func), 32'(FUNC_SUB));
    tick();
    chk1("forced_b_vld", b_rsp_vld, 1'b1);
    chk1("forced_a_vld", a_rsp_vld, 1'b0);
    chk32("forced_dst", rsp_dst, 32'd7);
    $display("[TB] forced B SUB 10-3 -> dst=%0d", rsp_dst);
    set_b(1'b0, 1'b0, 33'd0, 33'd0, FUNC_ADD);
    #1;
    chk1("a_regain_gnt", a_gnt, 1'b1);
    tick();
    chk1("a_regain_vld", a_rsp_vld, 1'b1);
    chk32("a_regain_dst", rsp_dst, 32'd2);

    // Locked burst, A idle: 4 grants, one empty slot, then B resumes.
    set_a(1'b0, 33'd0, 33'd0, FUNC_ADD);
    set_b(1'b1, 1'b1, 33'd5, 33'd2, FUNC_SUB);
    for (int i = 0; i < 7; i++) begin
      #1;
      chk1("burst_b_gnt", b_gnt, exp_burst[i]);
      chk1("burst_a_gnt", a_gnt, 1'b0);
      tick();
      chk1("burst_b_vld", b_rsp_vld, exp_burst[i]);
      if (exp_burst[i]) chk32("burst_dst", rsp_dst, 32'd3);
      $display("[TB] burst slot %0d b_vld=%0b", i, b_rsp_vld);
    end
    set_b(1'b0, 1'b0, 33'd0, 33'd0, FUNC_ADD);
    tick();

    // Locked burst with A arriving mid-burst: A takes the slot after the 4th B.
    set_b(1'b1, 1'b1, 33'd5, 33'd2, FUNC_SUB);
    #1;
    chk1("burst2_first_b", b_gnt, 1'b1);
    tick();
    set_a(1'b1, 33'd3, 33'd4, FUNC_ADD);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("burst2_b_gnt", b_gnt, 1'b1);
      chk1("burst2_a_held", a_gnt, 1'b0);
      tick();
    end
    #1;
    chk1("burst2_a_slot", a_gnt, 1'b1);
    chk1("burst2_b_out", b_gnt, 1'b0);
    tick();
    chk1("burst2_a_vld", a_rsp_vld, 1'b1);
    chk32("burst2_a_dst", rsp_dst, 32'd7);
    #1;
    chk1("burst2_arb_a", a_gnt, 1'b1);
    tick();
    set_a(1'b0, 33'd0, 33'd0, FUNC_ADD);
    set_b(1'b0, 1'b0, 33'd0, 33'd0, FUNC_ADD);
    tick();

    // Saturation and flag capture/hold.
    set_b(1'b1, 1'b0, 33'h0_7FFF_FFFF, 33'd1, FUNC_ADD);
    #1;
    chk1("sat_b_gnt", b_gnt, 1'b1);
    tick();
    chk1("sat_b_vld", b_rsp_vld, 1'b1);
    chk32("sat_dst", rsp_dst, 32'h7FFF_FFFF);
    chk1("sat_ov", rsp_ov, 1'b1);
    chk1("sat_neg", rsp_neg, 1'b0);
    chk1("sat_zr", rsp_zr, 1'b0);
    $display("[TB] B ADD 7FFFFFFF+1 -> dst=%h ov=%0b", rsp_dst, rsp_ov);
    set_b(1'b0, 1'b0, 33'd0, 33'd0, FUNC_ADD);
    tick();
    chk1("hold_b_vld", b_rsp_vld, 1'b0);
    chk1("hold_ov", rsp_ov, 1'b1);
    set_a(1'b1, 33'h1_8000_0000, 33'h1_FFFF_FFFF, FUNC_ADD);
    tick();
    chk32("negsat_dst", rsp_dst, 32'h8000_0000);
    chk1("negsat_ov", rsp_ov, 1'b1);
    chk1("negsat_neg", rsp_neg, 1'b1);
    set_a(1'b1, 33'd5, 33'd5, FUNC_SUB);
    tick();
    chk32("zero_dst", rsp_dst, 32'd0);
    chk1("zero_zr", rsp_zr, 1'b1);
    chk1("zero_ov", rsp_ov, 1'b0);
    set_a(1'b0, 33'd0, 33'd0, FUNC_ADD);
    tick();

    // Reset in the middle of a locked burst with a response in flight.
    set_b(1'b1, 1'b1, 33'd9, 33'd4, FUNC_SUB);
    #1;
    chk1("rstblk_g1", b_gnt, 1'b1);
    tick();
    #1;
    chk1("rstblk_g2", b_gnt, 1'b1);
    tick();
    rst = 1'b1;
    set_a(1'b1, 33'd3, 33'd4, FUNC_ADD);
    #1;
    chk1("rstblk_a_gnt", a_gnt, 1'b0);
    chk1("rstblk_b_gnt", b_gnt, 1'b0);
    chk1("rstblk_pending", b_rsp_vld, 1'b1);
    tick();
    chk1("rstblk_b_vld", b_rsp_vld, 1'b0);
    chk1("rstblk_a_vld", a_rsp_vld, 1'b0);
    rst = 1'b0;
    #1;
    chk1("rstblk_arb_a", a_gnt, 1'b1);
    chk1("rstblk_no_b", b_gnt, 1'b0);
    tick();
    set_a(1'b0, 33'd0, 33'd0, FUNC_ADD);
    set_b(1'b0, 1'b0, 33'd0, 33'd0, FUNC_ADD);
    tick();
    tick();

    // Random traffic: exclusive grants, each answered next cycle to its owner.
    prev_a = 1'b0;
    prev_b = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      chk1("rand_a_vld", a_rsp_vld, prev_a);
      chk1("rand_b_vld", b_rsp_vld, prev_b);
      set_a(1'($urandom_range(0, 1)), 33'($urandom), 33'($urandom), 3'($urandom_range(0, 7)));
      set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 33'($urandom),
            33'($urandom), 3'($urandom_range(0, 7)));
      #1;
      chk1("rand_excl", a_gnt & b_gnt, 1'b0);
      chk1("rand_a_noreq", a_gnt & ~a_req, 1'b0);
      chk1("rand_b_noreq", b_gnt & ~b_req, 1'b0);
      prev_a = a_gnt;
      prev_b = b_gnt;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
